// File: rtl/ftdi_bus_arbiter.sv
// Half-duplex arbiter for an FTDI synchronous FIFO bus: alternates between host-to-FPGA
// reads and FPGA-to-host writes, with per-direction burst limits when both sides are waiting.
//
// state    | meaning
// ---------|----------------------------------------------------------
// IDLE     | bus released (oe_n=1, data_oe=0); pick next direction
// RX_TURN  | FTDI drives the bus (oe_n=0), one turnaround cycle before reading
// RX_READ  | FTDI drives the bus, one word read per cycle rd_n is low
// TX_WRITE | FPGA drives the bus, one word written per cycle wr_n is low
module ftdi_bus_arbiter #(
  parameter int unsigned MAX_BURST = 64
) (
  input  logic       ftdiclk,
  input  logic       reset,
  input  logic       ftdi_rxf_n,
  input  logic       ftdi_txe_n,
  output logic       ftdi_rd_n,
  output logic       ftdi_wr_n,
  output logic       ftdi_oe_n,
  output logic       ftdi_siwu_n,
  input  logic [7:0] ftdi_data_in,
  output logic [7:0] ftdi_data_out,
  output logic       ftdi_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       grant_rx,
  output logic       grant_tx
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);
  localparam logic       DIR_RX  = 1'b0;
  localparam logic       DIR_TX  = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RX_TURN  = 2'd1,
    RX_READ  = 2'd2,
    TX_WRITE = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic       last_dir_q, last_dir_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;

  logic rx_pend, tx_pend;
  logic burst_max, rx_limit, tx_limit;
  logic rd_go, tx_rdy_int, wr_go;
  logic active;

  always_comb begin
    rx_pend   = !ftdi_rxf_n && rx_ready;
    tx_pend   = !ftdi_txe_n && tx_valid;
    burst_max = (burst_cnt_q == MAX_CNT);
    // Burst limit only bites when the other direction is actually waiting.
    rx_limit  = burst_max && tx_pend;
    tx_limit  = burst_max && rx_pend;
    rd_go      = (state_q == RX_READ) && rx_pend && !rx_limit;
    tx_rdy_int = (state_q == TX_WRITE) && !ftdi_txe_n && !tx_limit;
    wr_go      = tx_rdy_int && tx_valid;
  end

  always_comb begin
    state_d     = state_q;
    last_dir_d  = last_dir_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (rx_pend && (!tx_pend || last_dir_q == DIR_TX)) begin
          state_d     = RX_TURN;
          burst_cnt_d = '0;
        end else if (tx_pend) begin
          state_d     = TX_WRITE;
          burst_cnt_d = '0;
        end
      end
      RX_TURN: state_d = RX_READ;
      RX_READ: begin
        if (rd_go) begin
          if (!burst_max) burst_cnt_d = burst_cnt_q + 8'd1;
        end else begin
          state_d    = IDLE;
          last_dir_d = DIR_RX;
        end
      end
      TX_WRITE: begin
        if (wr_go) begin
          if (!burst_max) burst_cnt_d = burst_cnt_q + 8'd1;
        end else begin
          state_d    = IDLE;
          last_dir_d = DIR_TX;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ftdiclk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_dir_q  <= DIR_TX;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Reset masks every strobe so the bus is released even in the cycle reset is sampled.
  always_comb begin
    active        = !reset;
    ftdi_oe_n     = !(active && (state_q == RX_TURN || state_q == RX_READ));
    ftdi_rd_n     = !(active && rd_go);
    rx_valid      = active && rd_go;
    rx_data       = ftdi_data_in;
    tx_ready      = active && tx_rdy_int;
    ftdi_wr_n     = !(active && wr_go);
    ftdi_data_oe  = active && (state_q == TX_WRITE);
    ftdi_data_out = tx_data;
    ftdi_siwu_n   = 1'b1;
    grant_rx      = active && (state_q == RX_TURN || state_q == RX_READ);
    grant_tx      = active && (state_q == TX_WRITE);
  end

endmodule

// File: tb/tb_ftdi_bus_arbiter.sv
// Scoreboard bench for ftdi_bus_arbiter: models the FTDI FIFOs and the FPGA-side streams,
// checks every transferred byte in order and the burst/turnaround pattern.
module tb_ftdi_bus_arbiter;
  localparam int MAXB = 4;

  logic       ftdiclk = 1'b0;
  logic       reset;
  logic       ftdi_rxf_n, ftdi_txe_n;
  logic       ftdi_rd_n, ftdi_wr_n, ftdi_oe_n, ftdi_siwu_n;
  logic [7:0] ftdi_data_in, ftdi_data_out;
  logic       ftdi_data_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       grant_rx, grant_tx;

  always #5 ftdiclk = ~ftdiclk;

  ftdi_bus_arbiter #(.MAX_BURST(MAXB)) dut (
    .ftdiclk(ftdiclk), .reset(reset),
    .ftdi_rxf_n(ftdi_rxf_n), .ftdi_txe_n(ftdi_txe_n),
    .ftdi_rd_n(ftdi_rd_n), .ftdi_wr_n(ftdi_wr_n), .ftdi_oe_n(ftdi_oe_n), .ftdi_siwu_n(ftdi_siwu_n),
    .ftdi_data_in(ftdi_data_in), .ftdi_data_out(ftdi_data_out), .ftdi_data_oe(ftdi_data_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .grant_rx(grant_rx), .grant_tx(grant_tx)
  );

  typedef struct { int dir; int words; int gap; } burst_t;

  logic [7:0] host_q[$], src_q[$], exp_rx[$], exp_tx[$];
  burst_t     blog[$];

  logic reset_k = 1'b1, rx_rdy_k = 1'b1, tx_en_k = 1'b0, txe_blk_k = 1'b0;
  logic rd_f = 1'b0, tx_f = 1'b0, turn_prev = 1'b0;
  int   prev_dir = 0, idle_run = 0, bwords = 0, bgap = 0;
  int   rx_total = 0, tx_total = 0;
  int   n_vec = 0, n_err = 0;
  logic [7:0] dummy;

  task automatic chk(string tag, int obs, int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic send_host(logic [7:0] b);
    host_q.push_back(b);
    exp_rx.push_back(b);
  endtask

  task automatic send_src(logic [7:0] b);
    src_q.push_back(b);
    exp_tx.push_back(b);
  endtask

  task automatic drive_inputs();
    reset        = reset_k;
    rx_ready     = rx_rdy_k;
    ftdi_rxf_n   = (host_q.size() == 0);
    ftdi_data_in = (host_q.size() != 0) ? host_q[0] : 8'h00;
    ftdi_txe_n   = txe_blk_k;
    tx_valid     = tx_en_k && (src_q.size() != 0);
    tx_data      = (src_q.size() != 0) ? src_q[0] : 8'h00;
  endtask

  task automatic monitor();
    int cur;
    logic rd_x, wr_x, rx_hs, tx_hs;
    logic [7:0] e;
    cur   = grant_rx ? 1 : (grant_tx ? 2 : 0);
    rd_x  = !ftdi_rd_n && !ftdi_rxf_n;
    rx_hs = rx_valid && rx_ready;
    wr_x  = !ftdi_wr_n && !ftdi_txe_n;
    tx_hs = tx_valid && tx_ready;
    chk("oe_conflict", int'(ftdi_data_oe && !ftdi_oe_n), 0);
    if (rd_x || rx_hs) chk("rx_rd_sync", int'(rx_hs), int'(rd_x));
    if (rx_hs) begin
      if (exp_rx.size() == 0) chk("rx_extra_word", 1, 0);
      else begin e = exp_rx.pop_front(); chk("rx_data", rx_data, e); end
    end
    if (wr_x || tx_hs) chk("tx_wr_sync", int'(wr_x), int'(tx_hs));
    if (wr_x) begin
      chk("tx_data_oe", ftdi_data_oe, 1);
      if (exp_tx.size() == 0) chk("tx_extra_word", 1, 0);
      else begin e = exp_tx.pop_front(); chk("tx_data", ftdi_data_out, e); end
    end
    if (cur == 1 && prev_dir != 1) begin
      chk("rx_turn_oe_n", ftdi_oe_n, 0);
      chk("rx_turn_rd_n", ftdi_rd_n, 1);
    end
    if (turn_prev && cur == 1 && !ftdi_rxf_n && rx_ready) chk("rx_first_rd_n", ftdi_rd_n, 0);
    turn_prev = (cur == 1 && prev_dir != 1);
    if (cur != prev_dir) begin
      if (prev_dir != 0) blog.push_back('{prev_dir, bwords, bgap});
      if (cur != 0) begin
        bgap   = (prev_dir == 0) ? idle_run : 0;
        bwords = 0;
      end
    end
    if (cur == 0) idle_run++; else idle_run = 0;
    if (cur == 1 && rd_x) bwords++;
    if (cur == 2 && wr_x) bwords++;
    if (rx_hs) rx_total++;
    if (wr_x) tx_total++;
    rd_f = rd_x;
    tx_f = tx_hs;
    prev_dir = cur;
  endtask

  task automatic tick();
    @(posedge ftdiclk);
    if (rd_f && host_q.size() != 0) dummy = host_q.pop_front();
    if (tx_f && src_q.size() != 0) dummy = src_q.pop_front();
    #1;
    drive_inputs();
    @(negedge ftdiclk);
    monitor();
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((exp_rx.size() != 0 || exp_tx.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", exp_rx.size() + exp_tx.size(), 0);
    repeat (3) tick();
  endtask

  task automatic wait_rx(int target, int budget);
    int n = 0;
    while (rx_total < target && n < budget) begin tick(); n++; end
    chk("wait_rx_timeout", int'(rx_total >= target), 1);
  endtask

  task automatic wait_tx(int target, int budget);
    int n = 0;
    while (tx_total < target && n < budget) begin tick(); n++; end
    chk("wait_tx_timeout", int'(tx_total >= target), 1);
  endtask

  task automatic chk_burst(int idx, int dir, int words, int gap);
    if (idx >= blog.size()) chk($sformatf("burst%0d_missing", idx), blog.size(), idx + 1);
    else begin
      chk($sformatf("burst%0d_dir", idx), blog[idx].dir, dir);
      chk($sformatf("burst%0d_words", idx), blog[idx].words, words);
      if (gap >= 0) chk($sformatf("burst%0d_gap", idx), blog[idx].gap, gap);
    end
  endtask

  task automatic chk_released(string tag);
    chk({tag, "_rd_n"}, ftdi_rd_n, 1);
    chk({tag, "_wr_n"}, ftdi_wr_n, 1);
    chk({tag, "_oe_n"}, ftdi_oe_n, 1);
    chk({tag, "_siwu_n"}, ftdi_siwu_n, 1);
    chk({tag, "_data_oe"}, ftdi_data_oe, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_tx_ready"}, tx_ready, 0);
    chk({tag, "_grants"}, {grant_rx, grant_tx}, 0);
  endtask

  int base;

  initial begin
    drive_inputs();
    // reset behaviour
    tick();
    chk_released("rst0");
    repeat (2) tick();
    chk_released("rst2");
    reset_k = 1'b0;
    tick();
    chk_released("idle");

    // RX only: five host bytes, no TX traffic so no burst limit
    blog.delete();
    for (int i = 1; i <= 5; i++) send_host(8'(i));
    drain(60);
    chk_burst(0, 1, 5, -1);
    chk("rx_only_bursts", blog.size(), 1);

    // TX only: four bytes
    blog.delete();
    tx_en_k = 1'b1;
    for (int i = 0; i < 4; i++) send_src(8'hA0 + 8'(i));
    drain(60);
    chk_burst(0, 2, 4, -1);

    // txe_n rises after 2 of 6 words
    blog.delete();
    base = tx_total;
    for (int i = 0; i < 6; i++) send_src(8'h50 + 8'(i));
    wait_tx(base + 2, 40);
    txe_blk_k = 1'b1;
    tick();
    chk("txe_stop_wr_n", ftdi_wr_n, 1);
    chk("txe_stop_tx_ready", tx_ready, 0);
    chk("txe_stop_grant", grant_tx, 1);
    tick();
    chk("txe_stop_idle", {grant_rx, grant_tx}, 0);
    repeat (2) tick();
    txe_blk_k = 1'b0;
    drain(60);
    chk_burst(0, 2, 2, -1);
    chk_burst(1, 2, 4, -1);

    // rx_ready drops mid-burst
    blog.delete();
    base = rx_total;
    for (int i = 0; i < 6; i++) send_host(8'h10 + 8'(i));
    wait_rx(base + 3, 40);
    rx_rdy_k = 1'b0;
    tick();
    chk("rxrdy_stop_rd_n", ftdi_rd_n, 1);
    chk("rxrdy_stop_rx_valid", rx_valid, 0);
    chk("rxrdy_stop_grant", grant_rx, 1);
    tick();
    chk("rxrdy_stop_idle", grant_rx, 0);
    repeat (2) tick();
    rx_rdy_k = 1'b1;
    drain(60);
    chk_burst(0, 1, 3, -1);
    chk_burst(1, 1, 3, -1);

    // reset mid TX burst
    base = tx_total;
    for (int i = 0; i < 6; i++) send_src(8'hC0 + 8'(i));
    wait_tx(base + 2, 40);
    reset_k = 1'b1;
    tick();
    tick();
    chk_released("rst_mid_tx");
    src_q.delete();
    exp_tx.delete();

    // tie after reset: RX first, bursts alternate at the limit
    blog.delete();
    for (int i = 0; i < 6; i++) send_host(8'h30 + 8'(i));
    for (int i = 0; i < 6; i++) send_src(8'hB0 + 8'(i));
    tick();
    reset_k = 1'b0;
    drain(120);
    chk_burst(0, 1, MAXB, -1);
    chk_burst(1, 2, MAXB, 1);
    chk_burst(2, 1, 6 - MAXB, 1);
    chk_burst(3, 2, 6 - MAXB, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end
endmodule
